fpu_req_arbiter: RTL and testbench
==================================

Name: fpu_req_arbiter

Overview:
- Shares one FPU_Wrapper instance between NUM_REQ independent requesters (integer-pipe lanes, vector lanes, DMA-side converters).
- Round-robin arbitration selects the next requester. The block embeds the requester ID and a per-requester sequence number in the 4-bit FPU tag, latches one operation into an issue register, and drives the FPU in_valid/fpu_ready handshake.
- Returned results are steered back to the owning requester by tag, and the FPU cpu_ready back-pressure is driven from that requester.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2 or 4.
- OP_WIDTH, 64, IEEE operand/result width (MAN_WIDTH+EXP_WIDTH of the FPU).
- MAX_OUT, 2, maximum in-flight operations per requester, including the issue register; range 1..2^SEQ_W.
- ID_W, clog2(NUM_REQ), derived: requester-ID field, tag[3:4-ID_W].
- SEQ_W, 4-ID_W, derived: sequence field, tag[SEQ_W-1:0].

Ports:
- clk in 1 clock
- reset in 1 asynchronous, active-high reset
- req_valid in NUM_REQ per-requester request valid
- req_ready out NUM_REQ per-requester accept pulse
- req_op1 in NUM_REQ*OP_WIDTH operand 1, requester i at slice [i*OP_WIDTH +: OP_WIDTH]
- req_op2 in NUM_REQ*OP_WIDTH operand 2
- req_operator in NUM_REQ*3 FPU operator code
- req_rm in NUM_REQ*3 rounding mode
- fpu_in_valid out 1 to FPU in_valid
- fpu_ready in 1 from FPU fpu_ready
- fpu_tag out 4 to FPU tag
- fpu_op1 out OP_WIDTH to FPU inOp1
- fpu_op2 out OP_WIDTH to FPU inOp2
- fpu_operator out 3 to FPU operator
- fpu_rm out 3 to FPU rounding_mode
- fpu_result_valid in 1 from FPU result_valid
- fpu_tag_out in 4 from FPU tag_out
- fpu_result in OP_WIDTH from FPU result
- fpu_flags in 5 from FPU exceptionFlags
- fpu_cpu_ready out 1 to FPU cpu_ready
- rsp_valid out NUM_REQ per-requester result valid
- rsp_ready in NUM_REQ per-requester result accept
- rsp_result out OP_WIDTH shared result bus, valid for the lane with rsp_valid set
- rsp_flags out 5 shared exception flags
- err_spurious out 1 sticky: result arrived for a requester with zero outstanding operations

Behaviour:
- Reset values: all registers cleared; fpu_in_valid=0, req_ready=0, rsp_valid=0, err_spurious=0; rr_ptr=0; all outstanding counters and sequence counters = 0; issue register empty.
- Issue FSM has two states:
  - IDLE (issue register empty): eligible[i] = req_valid[i] & (out_cnt[i] < MAX_OUT). Grant goes to the first eligible i searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On grant: req_ready[g]=1 for one cycle (combinational from state and eligibility). The issue register latches op1, op2, operator, rm and tag={g, seq[g]}. seq[g] increments, wrapping to 0. out_cnt[g] increments. rr_ptr becomes g+1 mod NUM_REQ. Next state is ISSUE.
  - ISSUE: fpu_in_valid=1; all fpu_* issue outputs are driven from the issue register and stay stable. On fpu_in_valid & fpu_ready, go to IDLE. No new grant is made in the handshake cycle, so at most one accept per two cycles.
  - If no requester is eligible, stay in IDLE; rr_ptr does not change.
- Latency: request accepted in cycle N gives fpu_in_valid=1 in cycle N+1.
- Response path is purely combinational:
  - id = fpu_tag_out[3:SEQ_W].
  - rsp_valid[i] = fpu_result_valid & (id==i) & (out_cnt[i]!=0).
  - rsp_result = fpu_result; rsp_flags = fpu_flags.
  - fpu_cpu_ready = rsp_ready[id].
- Response handshake (rsp_valid[i] & rsp_ready[i]): out_cnt[i] decrements.
- Counter boundaries:
  - Increment and decrement on the same requester in the same cycle leave out_cnt unchanged.
  - out_cnt never exceeds MAX_OUT and never underflows.
- Spurious response: fpu_result_valid with out_cnt[id]==0 sets err_spurious (sticky until reset). fpu_cpu_ready is forced to 1 so the FPU drains the result, and no rsp_valid is raised.
- Requester back-pressure: a requester holding rsp_ready=0 stalls the FPU output only while its own result is presented. Its further requests are blocked once out_cnt reaches MAX_OUT.
- Reset mid-operation: all state is cleared immediately, including any held issue register and in-flight counts. The FPU shares the same reset, so no stale result returns.

Optional Feature:
- Macro: FPU_ARB_SEQCHK_EN.
- With the macro defined:
  - A per-requester expected-return sequence counter, exp_seq[i], is added.
  - On each response handshake, fpu_tag_out[SEQ_W-1:0] is compared to exp_seq[i], then exp_seq[i] increments with wrap.
  - A mismatch sets output err_seq (1 bit, sticky, reset 0).
- Without the macro: the err_seq port and the exp_seq logic are absent, and behaviour is otherwise identical.

Test Plan:
- Single request: requester 2 sends op1=0x3FF0000000000000, op2=0x4000000000000000, operator ADD. Expect req_ready[2] in cycle N, fpu_in_valid in N+1 with fpu_tag=4'b1000, and on the result rsp_valid[2]=1 with rsp_result=0x4008000000000000.
- Round-robin fairness: all 4 requesters hold req_valid high continuously. Expect grant order 0,1,2,3,0,... with fpu_tag upper bits following it, and no requester granted twice before the others are granted once.
- Outstanding limit: requester 0 with MAX_OUT=2, rsp_ready[0]=0. After 2 accepts, req_ready[0] stays 0 while requester 1 is still granted. Asserting rsp_ready[0] re-enables requester 0 on the cycle after the response handshake.
- FPU stall: fpu_ready=0 for 10 cycles in ISSUE. fpu_in_valid, fpu_op1 and fpu_tag must stay stable, and req_ready must stay all 0.
- Spurious result: inject fpu_result_valid with fpu_tag_out=4'b0100 while out_cnt[1]=0. Expect err_spurious=1 from the next cycle, fpu_cpu_ready=1, and rsp_valid=0.
- Reset mid-ISSUE: assert reset asynchronously while fpu_in_valid=1. Expect fpu_in_valid=0 immediately, and all counters 0 with rr_ptr=0 after release.

Source files
------------

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one FPU between NumReq requesters.
// Round-robin grant into a single issue register. The requester ID and a per-requester
// sequence number are packed into the 4-bit FPU tag. Results are steered back to the
// owning requester by tag.
// Optional: define FPU_ARB_SEQCHK_EN to add in-order return checking (err_seq_o).
module fpu_req_arbiter #(
  parameter int unsigned NumReq  = 4,   // 2 or 4
  parameter int unsigned OpWidth = 64,
  parameter int unsigned MaxOut  = 2    // 1..2^SeqW, includes the issue register
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  output logic [NumReq-1:0]         req_ready_o,
  input  logic [NumReq*OpWidth-1:0] req_op1_i,
  input  logic [NumReq*OpWidth-1:0] req_op2_i,
  input  logic [NumReq*3-1:0]       req_operator_i,
  input  logic [NumReq*3-1:0]       req_rm_i,
  output logic                      fpu_in_valid_o,
  input  logic                      fpu_ready_i,
  output logic [3:0]                fpu_tag_o,
  output logic [OpWidth-1:0]        fpu_op1_o,
  output logic [OpWidth-1:0]        fpu_op2_o,
  output logic [2:0]                fpu_operator_o,
  output logic [2:0]                fpu_rm_o,
  input  logic                      fpu_result_valid_i,
  input  logic [3:0]                fpu_tag_out_i,
  input  logic [OpWidth-1:0]        fpu_result_i,
  input  logic [4:0]                fpu_flags_i,
  output logic                      fpu_cpu_ready_o,
  output logic [NumReq-1:0]         rsp_valid_o,
  input  logic [NumReq-1:0]         rsp_ready_i,
  output logic [OpWidth-1:0]        rsp_result_o,
  output logic [4:0]                rsp_flags_o,
  output logic                      err_spurious_o
`ifdef FPU_ARB_SEQCHK_EN
  ,
  output logic                      err_seq_o
`endif
);

  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned SeqW = 4 - IdW;
  localparam int unsigned CntW = $clog2(MaxOut + 1);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]     out_cnt_q [NumReq];
  logic [CntW-1:0]     out_cnt_d [NumReq];
  logic [SeqW-1:0]     seq_q [NumReq];
  logic [SeqW-1:0]     seq_d [NumReq];
  logic [3:0]          iss_tag_q;
  logic [OpWidth-1:0]  iss_op1_q, iss_op2_q;
  logic [2:0]          iss_oper_q, iss_rm_q;
  logic                err_spurious_q, err_spurious_d;

  logic [NumReq-1:0]   eligible;
  logic                grant_vld;
  logic [IdW-1:0]      grant_id;
  logic [IdW-1:0]      scan_idx;
  logic                issue_load;
  logic [OpWidth-1:0]  sel_op1, sel_op2;
  logic [2:0]          sel_oper, sel_rm;
  logic [IdW-1:0]      rsp_id;
  logic                rsp_cnt_zero;
  logic [NumReq-1:0]   rsp_hs;

  // Eligibility: requester is asking and still has room for another in-flight op.
  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) begin
      eligible[i] = req_valid_i[i] & (out_cnt_q[i] < CntW'(MaxOut));
    end
  end

  // Round-robin search from rr_ptr_q; scanning backwards lets the nearest offset win.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      // NumReq is a power of two, so IdW-bit addition wraps modulo NumReq.
      scan_idx = rr_ptr_q + IdW'(k);
      if (eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_op1  = '0;
    sel_op2  = '0;
    sel_oper = '0;
    sel_rm   = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (grant_id == IdW'(i)) begin
        sel_op1  = req_op1_i[i*OpWidth +: OpWidth];
        sel_op2  = req_op2_i[i*OpWidth +: OpWidth];
        sel_oper = req_operator_i[i*3 +: 3];
        sel_rm   = req_rm_i[i*3 +: 3];
      end
    end
  end

  // Issue FSM: next state, accept pulse and FPU handshake.
  always_comb begin
    state_d        = state_q;
    req_ready_o    = '0;
    fpu_in_valid_o = 1'b0;
    issue_load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          req_ready_o[grant_id] = 1'b1;
          issue_load            = 1'b1;
          state_d               = StIssue;
        end
      end
      StIssue: begin
        fpu_in_valid_o = 1'b1;
        if (fpu_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign fpu_tag_o      = iss_tag_q;
  assign fpu_op1_o      = iss_op1_q;
  assign fpu_op2_o      = iss_op2_q;
  assign fpu_operator_o = iss_oper_q;
  assign fpu_rm_o       = iss_rm_q;

  // Response steering by tag ID; results for an idle requester are drained and flagged.
  always_comb begin
    rsp_id       = fpu_tag_out_i[3:SeqW];
    rsp_cnt_zero = (out_cnt_q[rsp_id] == '0);
    for (int i = 0; i < int'(NumReq); i++) begin
      rsp_valid_o[i] = fpu_result_valid_i & (rsp_id == IdW'(i)) & ~rsp_cnt_zero;
    end
    rsp_hs          = rsp_valid_o & rsp_ready_i;
    fpu_cpu_ready_o = (fpu_result_valid_i & rsp_cnt_zero) | rsp_ready_i[rsp_id];
    rsp_result_o    = fpu_result_i;
    rsp_flags_o     = fpu_flags_i;
    err_spurious_d  = err_spurious_q | (fpu_result_valid_i & rsp_cnt_zero);
  end

  // Outstanding/sequence counters and round-robin pointer update.
  always_comb begin
    rr_ptr_d = issue_load ? grant_id + IdW'(1) : rr_ptr_q;
    for (int i = 0; i < int'(NumReq); i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      seq_d[i]     = seq_q[i];
      if (issue_load && (grant_id == IdW'(i))) begin
        seq_d[i] = seq_q[i] + SeqW'(1);
        if (!rsp_hs[i]) out_cnt_d[i] = out_cnt_q[i] + CntW'(1);
      end else if (rsp_hs[i]) begin
        out_cnt_d[i] = out_cnt_q[i] - CntW'(1);
      end
    end
  end

  // State, counters and sticky error register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      err_spurious_q <= 1'b0;
      for (int i = 0; i < int'(NumReq); i++) begin
        out_cnt_q[i] <= '0;
        seq_q[i]     <= '0;
      end
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      err_spurious_q <= err_spurious_d;
      for (int i = 0; i < int'(NumReq); i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
        seq_q[i]     <= seq_d[i];
      end
    end
  end

  // Issue register: held stable while the FPU stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iss_tag_q  <= '0;
      iss_op1_q  <= '0;
      iss_op2_q  <= '0;
      iss_oper_q <= '0;
      iss_rm_q   <= '0;
    end else if (issue_load) begin
      iss_tag_q  <= {grant_id, seq_q[grant_id]};
      iss_op1_q  <= sel_op1;
      iss_op2_q  <= sel_op2;
      iss_oper_q <= sel_oper;
      iss_rm_q   <= sel_rm;
    end
  end

  assign err_spurious_o = err_spurious_q;

`ifdef FPU_ARB_SEQCHK_EN
  logic [SeqW-1:0] exp_seq_q [NumReq];
  logic [SeqW-1:0] exp_seq_d [NumReq];
  logic            err_seq_q, err_seq_d;

  // Results must return in issue order per requester.
  always_comb begin
    err_seq_d = err_seq_q;
    for (int i = 0; i < int'(NumReq); i++) begin
      exp_seq_d[i] = exp_seq_q[i];
      if (rsp_hs[i]) begin
        if (fpu_tag_out_i[SeqW-1:0] != exp_seq_q[i]) err_seq_d = 1'b1;
        exp_seq_d[i] = exp_seq_q[i] + SeqW'(1);
      end
    end
  end

  // Expected-sequence counters and sticky order error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_seq_q <= 1'b0;
      for (int i = 0; i < int'(NumReq); i++) exp_seq_q[i] <= '0;
    end else begin
      err_seq_q <= err_seq_d;
      for (int i = 0; i < int'(NumReq); i++) exp_seq_q[i] <= exp_seq_d[i];
    end
  end

  assign err_seq_o = err_seq_q;
`else
  // Sequence field of the returned tag is only inspected by the order checker.
  logic unused_tag_seq;
  assign unused_tag_seq = ^fpu_tag_out_i[SeqW-1:0];
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Bench for fpu_req_arbiter: directed stimulus, a behavioural model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_fpu_req_arbiter;
  localparam int N    = 4;
  localparam int W    = 64;
  localparam int MAXO = 2;
  localparam int SEQW = 2;

  logic           clk, rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_op1, req_op2;
  logic [N*3-1:0] req_operator, req_rm;
  logic           fpu_in_valid, fpu_ready, fpu_result_valid, fpu_cpu_ready, err_spurious;
  logic [3:0]     fpu_tag, fpu_tag_out;
  logic [W-1:0]   fpu_op1, fpu_op2, fpu_result, rsp_result;
  logic [2:0]     fpu_operator, fpu_rm;
  logic [4:0]     fpu_flags, rsp_flags;
`ifdef FPU_ARB_SEQCHK_EN
  logic           err_seq;
`endif

  fpu_req_arbiter dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_op1_i          (req_op1),
    .req_op2_i          (req_op2),
    .req_operator_i     (req_operator),
    .req_rm_i           (req_rm),
    .fpu_in_valid_o     (fpu_in_valid),
    .fpu_ready_i        (fpu_ready),
    .fpu_tag_o          (fpu_tag),
    .fpu_op1_o          (fpu_op1),
    .fpu_op2_o          (fpu_op2),
    .fpu_operator_o     (fpu_operator),
    .fpu_rm_o           (fpu_rm),
    .fpu_result_valid_i (fpu_result_valid),
    .fpu_tag_out_i      (fpu_tag_out),
    .fpu_result_i       (fpu_result),
    .fpu_flags_i        (fpu_flags),
    .fpu_cpu_ready_o    (fpu_cpu_ready),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_result_o       (rsp_result),
    .rsp_flags_o        (rsp_flags),
    .err_spurious_o     (err_spurious)
`ifdef FPU_ARB_SEQCHK_EN
    ,
    .err_seq_o          (err_seq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_busy;
  logic [3:0] m_tag;
  logic [W-1:0] m_op1, m_op2;
  logic [2:0] m_oper, m_rm;
  int         m_rr;
  int         m_cnt [N];
  int         m_seq [N];
  bit         m_spur;
`ifdef FPU_ARB_SEQCHK_EN
  int         m_exp [N];
  bit         m_errseq;
`endif
  int         mdl_g, mdl_id;
  bit         mdl_hs;

  // First requester at or after the pointer that is asking and below the in-flight limit.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req_valid[i] && m_cnt[i] < MAXO) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_rr   <= 0;
      m_spur <= 1'b0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] <= 0;
        m_seq[i] <= 0;
      end
`ifdef FPU_ARB_SEQCHK_EN
      m_errseq <= 1'b0;
      for (int i = 0; i < N; i++) m_exp[i] <= 0;
`endif
    end else begin
      mdl_g  = m_busy ? -1 : pick();
      mdl_id = int'(fpu_tag_out) / (1 << SEQW);
      mdl_hs = fpu_result_valid && m_cnt[mdl_id] > 0 && rsp_ready[mdl_id];
      if (mdl_g >= 0) begin
        m_busy <= 1'b1;
        m_tag  <= 4'(mdl_g * (1 << SEQW) + m_seq[mdl_g]);
        m_op1  <= req_op1[mdl_g*W +: W];
        m_op2  <= req_op2[mdl_g*W +: W];
        m_oper <= req_operator[mdl_g*3 +: 3];
        m_rm   <= req_rm[mdl_g*3 +: 3];
        m_rr   <= (mdl_g + 1) % N;
      end else if (m_busy && fpu_ready) begin
        m_busy <= 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        m_cnt[i] <= m_cnt[i] + ((i == mdl_g) ? 1 : 0) - ((mdl_hs && i == mdl_id) ? 1 : 0);
        m_seq[i] <= (i == mdl_g) ? (m_seq[i] + 1) % (1 << SEQW) : m_seq[i];
      end
      if (fpu_result_valid && m_cnt[mdl_id] == 0) m_spur <= 1'b1;
`ifdef FPU_ARB_SEQCHK_EN
      if (mdl_hs) begin
        if (int'(fpu_tag_out) % (1 << SEQW) != m_exp[mdl_id]) m_errseq <= 1'b1;
        m_exp[mdl_id] <= (m_exp[mdl_id] + 1) % (1 << SEQW);
      end
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    int e, cid;
    logic [N-1:0] exp_rr, exp_rv;
    logic exp_cr;
    if (!rst) begin
      e      = m_busy ? -1 : pick();
      exp_rr = (e < 0) ? '0 : N'(1 << e);
      chk("m_req_ready", 64'(req_ready), 64'(exp_rr));
      chk("m_fpu_in_valid", 64'(fpu_in_valid), 64'(m_busy));
      if (m_busy) begin
        chk("m_fpu_tag", 64'(fpu_tag), 64'(m_tag));
        chk("m_fpu_op1", fpu_op1, m_op1);
        chk("m_fpu_op2", fpu_op2, m_op2);
        chk("m_fpu_operator", 64'(fpu_operator), 64'(m_oper));
        chk("m_fpu_rm", 64'(fpu_rm), 64'(m_rm));
      end
      cid    = int'(fpu_tag_out) / (1 << SEQW);
      exp_rv = (fpu_result_valid && m_cnt[cid] > 0) ? N'(1 << cid) : '0;
      exp_cr = (fpu_result_valid && m_cnt[cid] == 0) ? 1'b1 : rsp_ready[cid];
      chk("m_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("m_fpu_cpu_ready", 64'(fpu_cpu_ready), 64'(exp_cr));
      if (fpu_result_valid) begin
        chk("m_rsp_result", rsp_result, fpu_result);
        chk("m_rsp_flags", 64'(rsp_flags), 64'(fpu_flags));
      end
      chk("m_err_spurious", 64'(err_spurious), 64'(m_spur));
`ifdef FPU_ARB_SEQCHK_EN
      chk("m_err_seq", 64'(err_seq), 64'(m_errseq));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid        = '0;
    req_op1          = '0;
    req_op2          = '0;
    req_operator     = '0;
    req_rm           = '0;
    fpu_ready        = 1'b0;
    fpu_result_valid = 1'b0;
    fpu_tag_out      = '0;
    fpu_result       = '0;
    fpu_flags        = '0;
    rsp_ready        = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [2:0] rm);
    req_op1[i*W +: W]      = a;
    req_op2[i*W +: W]      = b;
    req_operator[i*3 +: 3] = op;
    req_rm[i*3 +: 3]       = rm;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int gq[$];
    logic [3:0] tq[$];
    logic [3:0] exp_tags [8];
    int n0, n1, n1_after, r0_after;
    exp_tags = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13};

    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_fpu_in_valid", 64'(fpu_in_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_err_spurious", 64'(err_spurious), 64'd0);
    rst = 1'b0;
    tick();

    // Single request from requester 2
    rsp_ready = 4'hF;
    fpu_ready = 1'b1;
    set_req(2, 64'h3FF0000000000000, 64'h4000000000000000, 3'b000, 3'b000);
    req_valid = 4'b0100;
    #1;
    chk("t1_req_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    #1;
    chk("t1_in_valid", 64'(fpu_in_valid), 64'd1);
    chk("t1_tag", 64'(fpu_tag), 64'h8);
    chk("t1_op1", fpu_op1, 64'h3FF0000000000000);
    tick();
    fpu_result_valid = 1'b1;
    fpu_tag_out      = 4'b1000;
    fpu_result       = 64'h4008000000000000;
    #1;
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("t1_rsp_result", rsp_result, 64'h4008000000000000);
    tick();
    fpu_result_valid = 1'b0;
    tick();

    // Round-robin fairness with all requesters asking
    do_reset();
    rsp_ready = 4'hF;
    fpu_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 64'(i + 1), 64'(i + 17), 3'(i), 3'(i));
    req_valid = 4'hF;
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
      if (fpu_in_valid) tq.push_back(fpu_tag);
      tick();
    end
    req_valid = '0;
    chk("t2_grant_count", 64'(gq.size()), 64'd8);
    chk("t2_tag_count", 64'(tq.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < gq.size()) chk("t2_grant_order", 64'(gq[k]), 64'(k % 4));
      if (k < tq.size()) chk("t2_tag_order", 64'(tq[k]), 64'(exp_tags[k]));
    end
    for (int k = 0; k < 8; k++) begin
      fpu_result_valid = 1'b1;
      fpu_tag_out      = exp_tags[k];
      fpu_result       = 64'(k) * 64'h0101;
      fpu_flags        = 5'(k);
      #1;
      chk("t2_drain_rsp_valid", 64'(rsp_valid), 64'(1 << (k % 4)));
      tick();
    end
    fpu_result_valid = 1'b0;
    tick();

    // Outstanding limit with requester 0 back-pressured
    do_reset();
    rsp_ready = 4'b1110;
    fpu_ready = 1'b1;
    set_req(0, 64'hAAAA, 64'hBBBB, 3'd1, 3'd2);
    set_req(1, 64'hCCCC, 64'hDDDD, 3'd3, 3'd4);
    req_valid = 4'b0011;
    n0 = 0; n1 = 0; n1_after = 0; r0_after = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (n0 >= 2 && req_ready[0]) r0_after++;
      if (n0 >= 2 && req_ready[1]) n1_after++;
      if (req_ready[0]) n0++;
      if (req_ready[1]) n1++;
      tick();
    end
    chk("t3_grants_req0", 64'(n0), 64'd2);
    chk("t3_grants_req1", 64'(n1), 64'd2);
    chk("t3_req0_blocked", 64'(r0_after), 64'd0);
    chk("t3_req1_after_sat", 64'(n1_after), 64'd1);
    fpu_result_valid = 1'b1;
    fpu_tag_out      = 4'b0000;
    fpu_result       = 64'h1234;
    #1;
    chk("t3_rsp_valid_held", 64'(rsp_valid), 64'h1);
    chk("t3_cpu_ready_held", 64'(fpu_cpu_ready), 64'd0);
    tick();
    tick();
    chk("t3_still_blocked", 64'(req_ready), 64'd0);
    rsp_ready = 4'hF;
    #1;
    chk("t3_cpu_ready_go", 64'(fpu_cpu_ready), 64'd1);
    tick();
    fpu_result_valid = 1'b0;
    #1;
    chk("t3_reenabled", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    tick();

    // FPU stall for 10 cycles in ISSUE
    do_reset();
    rsp_ready = 4'hF;
    fpu_ready = 1'b0;
    set_req(1, 64'h400921FB54442D18, 64'h3FF0000000000000, 3'd2, 3'd1);
    req_valid = 4'b0010;
    #1;
    chk("t4_req_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t4_in_valid", 64'(fpu_in_valid), 64'd1);
      chk("t4_op1", fpu_op1, 64'h400921FB54442D18);
      chk("t4_tag", 64'(fpu_tag), 64'h4);
      chk("t4_no_accept", 64'(req_ready), 64'd0);
      tick();
    end
    fpu_ready = 1'b1;
    req_valid = '0;
    tick();
    #1;
    chk("t4_released", 64'(fpu_in_valid), 64'd0);
    tick();

    // Spurious result for requester 1
    do_reset();
    rsp_ready        = '0;
    fpu_result_valid = 1'b1;
    fpu_tag_out      = 4'b0100;
    fpu_result       = 64'hDEAD;
    #1;
    chk("t5_cpu_ready", 64'(fpu_cpu_ready), 64'd1);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_err_before", 64'(err_spurious), 64'd0);
    tick();
    fpu_result_valid = 1'b0;
    #1;
    chk("t5_err_set", 64'(err_spurious), 64'd1);
    tick();
    chk("t5_err_sticky", 64'(err_spurious), 64'd1);

    // Reset asserted mid-ISSUE
    fpu_ready = 1'b0;
    set_req(2, 64'h5555, 64'h6666, 3'd0, 3'd0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #1;
    chk("t6_in_issue", 64'(fpu_in_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_in_valid", 64'(fpu_in_valid), 64'd0);
    chk("t6_async_err", 64'(err_spurious), 64'd0);
    tick();
    tick();
    rst       = 1'b0;
    fpu_ready = 1'b1;
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    #1;
    chk("t6_rr_zero", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0100;
    tick();
    chk("t6_cnt2_first", 64'(req_ready), 64'h4);
    tick();
    tick();
    chk("t6_cnt2_second", 64'(req_ready), 64'h4);
    tick();
    tick();
    chk("t6_cnt2_full", 64'(req_ready), 64'd0);
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
